fir_accum_sequencer: RTL and testbench

//  Controls the shared 32-bit ripple-carry adder that performs the FIR tap accumulation.
//  - Accepts one tap product per handshake and drives the adder operands.
//  - Registers the adder sum back into the accumulator.
//  - After NUM_TAPS products, presents the filter output sample with a valid/ready handshake.
//  - Sits between the tap multiplier stream and the FIR output register.

---
 rtl/fir_pkg.sv | 13 +
 rtl/ripple_carry_adder_32bit.sv | 21 ++
 rtl/fir_accum_sequencer.sv | 109 ++++++++++
 tb/tb_fir_accum_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: datapath widths, tap count and the accumulation
// sequencer state encoding.
package fir_pkg;

    localparam int FIR_DATA_W   = 32;
    localparam int FIR_NUM_TAPS = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } fir_state_e;

endpackage

// File: rtl/ripple_carry_adder_32bit.sv
// Shared 32-bit ripple-carry adder used for the FIR tap accumulation.
// Arithmetic wraps modulo 2^32; there is no carry-out.
module ripple_carry_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);

    logic [31:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < 31) begin : g_c
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/fir_accum_sequencer.sv
// Sequences NUM_TAPS tap products through the shared adder into an accumulator
// and presents each finished sample, with a sticky signed-overflow flag.
module fir_accum_sequencer
    import fir_pkg::*;
#(
    parameter int  NUM_TAPS = FIR_NUM_TAPS,
    parameter int  DATA_W   = FIR_DATA_W,
    localparam int CNT_W    = $clog2(NUM_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    input  logic [DATA_W-1:0] add_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  tap_cnt,
    output logic              busy
);

    fir_state_e        state, state_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ovf, ovf_nxt;
    logic              accept;
    logic              sovf;

    // Adder operands are always driven; they only matter on an ACCUM accept.
    assign add_a   = acc;
    assign add_b   = in_data;
    assign add_cin = 1'b0;
    assign tap_cnt = cnt;

    // Same-sign operands producing a sum of the other sign.
    assign sovf = (add_a[DATA_W-1] == add_b[DATA_W-1]) &
                  (add_sum[DATA_W-1] != add_a[DATA_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_ovf   = 1'b0;
        accept    = 1'b0;

        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                // A product offered alongside clear is dropped.
                accept   = in_valid & ~clear;
                if (accept) begin
                    acc_nxt = add_sum;
                    ovf_nxt = ovf | sovf;
                    if (cnt == CNT_W'(NUM_TAPS - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc;
                out_ovf   = ovf;
                if (out_ready) begin
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase

        if (clear) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end

        busy = (cnt != '0) | out_valid;
    end

endmodule

// File: tb/tb_fir_accum_sequencer.sv
// Scoreboard bench for fir_accum_sequencer wired to the shared ripple-carry adder.
module tb_fir_accum_sequencer;
    import fir_pkg::*;

    localparam int NT = FIR_NUM_TAPS;
    localparam int DW = FIR_DATA_W;
    localparam int CW = $clog2(NT);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] add_a, add_b, add_sum;
    logic          add_cin;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_ovf;
    logic [CW-1:0] tap_cnt;
    logic          busy;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            nout  = 0;
    logic [DW:0]   sb_q[$];
    logic [DW-1:0] fr[NT];

    always #5 clk = ~clk;

    fir_accum_sequencer dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .tap_cnt(tap_cnt), .busy(busy)
    );

    ripple_carry_adder_32bit u_add (
        .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every handshake pops one expected {ovf, data}.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_out", 64'(out_data), 64'hdead);
            end else begin
                logic [DW:0] e;
                e = sb_q.pop_front();
                chk("sb_data", 64'(out_data), 64'(e[DW-1:0]));
                chk("sb_ovf", 64'(out_ovf), 64'(e[DW]));
            end
            nout++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the product was taken.
    task automatic send(input logic [DW-1:0] d);
        logic took;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            took = in_ready && !clear;
            tick();
            n++;
        end while (!took && n < 200);
        if (!took) chk("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        logic [DW-1:0] s, a;
        logic          ov;
        a  = '0;
        ov = 1'b0;
        for (int i = 0; i < NT; i++) begin
            s  = a + fr[i];
            ov = ov | ((a[DW-1] == fr[i][DW-1]) && (s[DW-1] != a[DW-1]));
            a  = s;
        end
        sb_q.push_back({ov, a});
        for (int i = 0; i < NT; i++) begin
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) tick();
            send(fr[i]);
        end
    endtask

    task automatic wait_out(input int target);
        int n;
        n = 0;
        while (nout < target && n < 100) begin
            tick();
            n++;
        end
        chk("wait_out", 64'(nout), 64'(target));
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < NT; i++) fr[i] = v;
    endtask

    task automatic chk_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_data"},  64'(out_data),  64'(0));
        chk({tag, "_out_ovf"},   64'(out_ovf),   64'(0));
        chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_tap_cnt"},   64'(tap_cnt),   64'(0));
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_vals("reset");
        tick();
        rst = 1'b0;
        chk("add_cin", 64'(add_cin), 64'(0));

        // 1: sixteen ones, sample valid one cycle after the last accept
        fill(32'd1);
        send_frame(0);
        @(negedge clk);
        chk("t1_latency", 64'(out_valid), 64'(1));
        tick();
        wait_out(1);

        // 2: back-pressure holds the sample, release restarts the next cycle
        out_ready = 1'b0;
        send_frame(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_valid_hold", 64'(out_valid), 64'(1));
            chk("t2_data_hold",  64'(out_data),  64'(16));
            chk("t2_in_ready",   64'(in_ready),  64'(0));
            tick();
        end
        chk("t2_no_early_out", 64'(nout), 64'(1));
        out_ready = 1'b1;
        sb_q.push_back({1'b0, 32'd16});
        in_valid = 1'b1;
        in_data  = 32'd1;
        @(negedge clk);
        chk("t2_rel_in_ready0", 64'(in_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("t2_rel_in_ready1", 64'(in_ready), 64'(1));
        chk("t2_rel_cnt0", 64'(tap_cnt), 64'(0));
        tick();
        @(negedge clk);
        chk("t2_rel_cnt1", 64'(tap_cnt), 64'(1));
        tick();
        for (int i = 0; i < NT - 2; i++) send(32'd1);
        wait_out(3);

        // 3: signed overflow is sticky for its frame only
        fill(32'd0);
        fr[0] = 32'h7FFF_FFFF;
        fr[1] = 32'd1;
        send_frame(0);
        wait_out(4);
        fill(32'd0);
        send_frame(0);
        wait_out(5);

        // 4: clear mid-frame drops the partial sum and the concurrent product
        for (int i = 0; i < 7; i++) send(32'd5);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd9;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_cnt_after_clear", 64'(tap_cnt), 64'(0));
        chk("t4_busy_after_clear", 64'(busy), 64'(0));
        tick();
        fill(32'd2);
        send_frame(0);
        wait_out(6);
        repeat (3) tick();
        chk("t4_single_out", 64'(nout), 64'(6));

        // 5: reset mid-frame, then a frame of -1
        for (int i = 0; i < 10; i++) send(32'd3);
        rst = 1'b1;
        tick();
        chk_reset_vals("t5_rst");
        tick();
        rst = 1'b0;
        fill(32'hFFFF_FFFF);
        send_frame(0);
        wait_out(7);

        // 6: products 1..16 with random input bubbles
        for (int i = 0; i < NT; i++) fr[i] = 32'(i + 1);
        send_frame(3);
        wait_out(8);

        repeat (2) tick();
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
